// File: rtl/shift_rotate_seq.sv
// Multi-cycle x86-style shift/rotate unit: one bit position per SHIFT cycle,
// with result and FLAGS image registered on entry to DONE.
module shift_rotate_seq #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned COUNT_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic                  is_8_bit,
    input  logic [WIDTH-1:0]      a,
    input  logic [COUNT_BITS-1:0] count,
    input  logic [15:0]           flags_in,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      out,
    output logic [15:0]           flags_out
);

    localparam int unsigned CF_BIT = 0;
    localparam int unsigned PF_BIT = 2;
    localparam int unsigned ZF_BIT = 6;
    localparam int unsigned SF_BIT = 7;
    localparam int unsigned OF_BIT = 11;

    localparam logic [2:0] OP_SHL = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SAR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
    localparam logic [2:0] OP_RCL = 3'd5;
    localparam logic [2:0] OP_RCR = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    localparam logic [WIDTH-1:0] MASK_8 = WIDTH'(8'hFF);
    localparam logic [WIDTH-1:0] MSB_8  = WIDTH'(8'h80);
    localparam logic [WIDTH-1:0] MSB_W  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [15:0]      flags_lat_q, flags_lat_d;
    logic [15:0]      flags_out_q, flags_out_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             is8_q, is8_d;
    logic             cf_q, cf_d;
    logic             orig_msb_q, orig_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [4:0]       n_c;
    logic [WIDTH-1:0] mask_c, msb_c, shl_c, in_mask_c;
    logic [WIDTH-1:0] step_val;
    logic             step_cf, work_msb, work_lsb;
    logic             res_msb, res_msb2, of_c;
    logic [15:0]      step_flags;

    // Count is taken modulo 32 regardless of the port width.
    if (COUNT_BITS > 5) begin : g_cnt_wide
        logic unused_count_hi;
        assign n_c             = count[4:0];
        assign unused_count_hi = |count[COUNT_BITS-1:5];
    end else begin : g_cnt_narrow
        assign n_c = 5'(count);
    end

    // One-bit step of the working value within the active width.
    always_comb begin : step_logic
        mask_c   = is8_q ? MASK_8 : '1;
        msb_c    = is8_q ? MSB_8 : MSB_W;
        work_msb = |(work_q & msb_c);
        work_lsb = work_q[0];
        shl_c    = (work_q << 1) & mask_c;
        step_val = work_q;
        step_cf  = cf_q;
        case (op_q)
            OP_SHL: begin
                step_val = shl_c;
                step_cf  = work_msb;
            end
            OP_SHR: begin
                step_val = work_q >> 1;
                step_cf  = work_lsb;
            end
            OP_SAR: begin
                step_val = (work_q >> 1) | (work_msb ? msb_c : '0);
                step_cf  = work_lsb;
            end
            OP_ROL: begin
                step_val = shl_c | WIDTH'(work_msb);
                step_cf  = work_msb;
            end
            OP_ROR: begin
                step_val = (work_q >> 1) | (work_lsb ? msb_c : '0);
                step_cf  = work_lsb;
            end
            OP_RCL: begin
                step_val = shl_c | WIDTH'(cf_q);
                step_cf  = work_msb;
            end
            OP_RCR: begin
                step_val = (work_q >> 1) | (cf_q ? msb_c : '0);
                step_cf  = work_lsb;
            end
            default: begin
                step_val = work_q;
                step_cf  = cf_q;
            end
        endcase
    end

    // FLAGS image as it would be if this step were the last one.
    always_comb begin : result_flags
        res_msb  = |(step_val & msb_c);
        res_msb2 = |(step_val & (msb_c >> 1));
        case (op_q)
            OP_SHL, OP_ROL, OP_RCL: of_c = res_msb ^ step_cf;
            OP_SHR:                 of_c = orig_msb_q;
            OP_ROR, OP_RCR:         of_c = res_msb ^ res_msb2;
            default:                of_c = 1'b0;
        endcase
        step_flags         = flags_lat_q;
        step_flags[CF_BIT] = step_cf;
        step_flags[OF_BIT] = of_c;
        if (op_q == OP_SHL || op_q == OP_SHR || op_q == OP_SAR) begin
            step_flags[ZF_BIT] = (step_val == '0);
            step_flags[SF_BIT] = res_msb;
            step_flags[PF_BIT] = ~^step_val[7:0];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin : next_state
        state_d     = state_q;
        work_d      = work_q;
        out_d       = out_q;
        flags_lat_d = flags_lat_q;
        flags_out_d = flags_out_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        is8_d       = is8_q;
        cf_d        = cf_q;
        orig_msb_d  = orig_msb_q;
        in_mask_c   = is_8_bit ? MASK_8 : '1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d      = a & in_mask_c;
                    op_d        = op;
                    is8_d       = is_8_bit;
                    flags_lat_d = flags_in;
                    cf_d        = flags_in[CF_BIT];
                    orig_msb_d  = is_8_bit ? a[7] : a[WIDTH-1];
                    cnt_d       = n_c;
                    if (n_c == 5'd0 || op == OP_RSV) begin
                        state_d     = DONE;
                        out_d       = a & in_mask_c;
                        flags_out_d = flags_in;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = step_val;
                cf_d   = step_cf;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d     = DONE;
                    out_d       = step_val;
                    flags_out_d = step_flags;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            work_q      <= '0;
            out_q       <= '0;
            flags_lat_q <= '0;
            flags_out_q <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            is8_q       <= 1'b0;
            cf_q        <= 1'b0;
            orig_msb_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            out_q       <= out_d;
            flags_lat_q <= flags_lat_d;
            flags_out_q <= flags_out_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            is8_q       <= is8_d;
            cf_q        <= cf_d;
            orig_msb_q  <= orig_msb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out       = out_q;
    assign flags_out = flags_out_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed bench for shift_rotate_seq: a 16-bit instance (5-bit count) and a
// 32-bit instance (6-bit count) checked against hand-computed results.
module tb_shift_rotate_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start16, start32;
    logic [2:0]  op;
    logic        is_8_bit;
    logic [15:0] a16;
    logic [31:0] a32;
    logic [5:0]  count;
    logic [15:0] flags_in;

    logic        busy16, done16, busy32, done32;
    logic [15:0] out16, flags16, flags32;
    logic [31:0] out32;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    shift_rotate_seq #(.WIDTH(16), .COUNT_BITS(5)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op), .is_8_bit(is_8_bit),
        .a(a16), .count(count[4:0]), .flags_in(flags_in),
        .busy(busy16), .done(done16), .out(out16), .flags_out(flags16)
    );

    shift_rotate_seq #(.WIDTH(32), .COUNT_BITS(6)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op), .is_8_bit(is_8_bit),
        .a(a32), .count(count), .flags_in(flags_in),
        .busy(busy32), .done(done32), .out(out32), .flags_out(flags32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic sel_busy(input logic w32);
        return w32 ? busy32 : busy16;
    endfunction

    function automatic logic sel_done(input logic w32);
        return w32 ? done32 : done16;
    endfunction

    function automatic logic [31:0] sel_out(input logic w32);
        return w32 ? out32 : 32'(out16);
    endfunction

    function automatic logic [15:0] sel_flags(input logic w32);
        return w32 ? flags32 : flags16;
    endfunction

    task automatic pulse_start(input logic w32);
        if (w32) start32 = 1'b1;
        else     start16 = 1'b1;
    endtask

    // Entered and left at posedge+1.  exp_lat is edges from the start edge to done.
    task automatic do_op(input string tag, input logic w32, input logic [2:0] op_i,
                         input logic is8_i, input logic [31:0] a_i, input logic [5:0] cnt_i,
                         input logic [15:0] fl_i, input int exp_lat,
                         input logic [31:0] exp_out, input logic [15:0] exp_fl,
                         input logic poke);
        int cyc;
        int busy_cyc;
        op       = op_i;
        is_8_bit = is8_i;
        a16      = a_i[15:0];
        a32      = a_i;
        count    = cnt_i;
        flags_in = fl_i;
        pulse_start(w32);
        @(posedge clk); #1;
        start16 = 1'b0;
        start32 = 1'b0;
        cyc      = 1;
        busy_cyc = 0;
        while (!sel_done(w32) && cyc < 40) begin
            if (sel_busy(w32)) busy_cyc++;
            if (poke && cyc == 1) begin
                pulse_start(w32);
                a16   = 16'h5A5A;
                a32   = 32'h5A5A_5A5A;
                op    = 3'd7;
                count = 6'd0;
            end
            @(posedge clk); #1;
            start16 = 1'b0;
            start32 = 1'b0;
            cyc++;
        end
        check($sformatf("%s_latency", tag), 32'(cyc), 32'(exp_lat));
        check($sformatf("%s_busy_cycles", tag), 32'(busy_cyc), 32'(exp_lat - 1));
        check($sformatf("%s_busy_at_done", tag), 32'(sel_busy(w32)), 32'd0);
        check($sformatf("%s_out", tag), sel_out(w32), exp_out);
        check($sformatf("%s_flags", tag), 32'(sel_flags(w32)), 32'(exp_fl));
        // A start in the DONE cycle must be ignored.
        op       = 3'd0;
        is_8_bit = 1'b0;
        count    = 6'd3;
        pulse_start(w32);
        @(posedge clk); #1;
        start16 = 1'b0;
        start32 = 1'b0;
        check($sformatf("%s_ign_busy", tag), 32'(sel_busy(w32)), 32'd0);
        check($sformatf("%s_ign_done", tag), 32'(sel_done(w32)), 32'd0);
        check($sformatf("%s_hold_out", tag), sel_out(w32), exp_out);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        start16  = 1'b1;
        start32  = 1'b1;
        op       = 3'd0;
        is_8_bit = 1'b0;
        a16      = 16'h1111;
        a32      = 32'h2222_2222;
        count    = 6'd0;
        flags_in = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_done16", 32'(done16), 32'd0);
        check("rst_out16", 32'(out16), 32'd0);
        check("rst_flags16", 32'(flags16), 32'd0);
        check("rst_done32", 32'(done32), 32'd0);
        check("rst_out32", out32, 32'd0);
        reset   = 1'b0;
        start16 = 1'b0;
        start32 = 1'b0;

        //    tag          w32   op    is8   a              cnt    flags    lat  out            flags    poke
        do_op("shl16",     1'b0, 3'd0, 1'b0, 32'h0000_8001, 6'd1,  16'h0000, 2,  32'h0000_0002, 16'h0801, 1'b0);
        do_op("sar8",      1'b0, 3'd2, 1'b1, 32'h0000_0080, 6'd3,  16'h0000, 4,  32'h0000_00F0, 16'h0084, 1'b0);
        do_op("rcl8_9",    1'b0, 3'd5, 1'b1, 32'h0000_0081, 6'd9,  16'h0001, 10, 32'h0000_0081, 16'h0001, 1'b0);
        do_op("cnt20_32",  1'b1, 3'd0, 1'b0, 32'h1234_5678, 6'h20, 16'h0ABC, 1,  32'h1234_5678, 16'h0ABC, 1'b0);
        do_op("cnt21_shr8",1'b1, 3'd1, 1'b1, 32'h1234_5681, 6'h21, 16'h0000, 2,  32'h0000_0040, 16'h0801, 1'b0);
        do_op("ror32",     1'b1, 3'd4, 1'b0, 32'h0000_0001, 6'd1,  16'h0000, 2,  32'h8000_0000, 16'h0801, 1'b1);
        do_op("rsvd_op",   1'b0, 3'd7, 1'b0, 32'h0000_1234, 6'd5,  16'h08D5, 1,  32'h0000_1234, 16'h08D5, 1'b0);
        do_op("n0_zext8",  1'b0, 3'd4, 1'b1, 32'h0000_BEEF, 6'd0,  16'hFFFF, 1,  32'h0000_00EF, 16'hFFFF, 1'b0);
        do_op("shr16_15",  1'b0, 3'd1, 1'b0, 32'h0000_8000, 6'd15, 16'h0000, 16, 32'h0000_0001, 16'h0800, 1'b1);
        do_op("rol16_4",   1'b0, 3'd3, 1'b0, 32'h0000_8001, 6'd4,  16'h00C4, 5,  32'h0000_0018, 16'h00C4, 1'b0);
        do_op("rcr8",      1'b0, 3'd6, 1'b1, 32'h0000_0001, 6'd1,  16'h0010, 2,  32'h0000_0000, 16'h0011, 1'b0);
        do_op("shl8_zero", 1'b0, 3'd0, 1'b1, 32'h0000_ABFF, 6'd8,  16'h0000, 9,  32'h0000_0000, 16'h0845, 1'b0);
        do_op("sar16_31",  1'b0, 3'd2, 1'b0, 32'h0000_8000, 6'd31, 16'h0000, 32, 32'h0000_FFFF, 16'h0085, 1'b0);

        // Reset during the second SHIFT cycle aborts the operation.
        op       = 3'd0;
        is_8_bit = 1'b0;
        a16      = 16'h0001;
        count    = 6'd5;
        flags_in = 16'h0000;
        start16  = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        check("mid_busy1", 32'(busy16), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 32'(busy16), 32'd0);
        check("midrst_done", 32'(done16), 32'd0);
        check("midrst_out", 32'(out16), 32'd0);
        check("midrst_flags", 32'(flags16), 32'd0);
        check("midrst_out32", out32, 32'd0);
        reset = 1'b0;

        do_op("post_rst",  1'b0, 3'd3, 1'b0, 32'h0000_1234, 6'd8,  16'h0001, 9,  32'h0000_3412, 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
